// File: rtl/bkm_steps_scoreboard.sv
// Scoreboard that times each start->done test, records verdicts and event counts.
// Optional BKM_SCB_STICKY_FAIL_EN: fail latches on first errored result or timeout until srst.
module bkm_steps_scoreboard #(
  parameter int WCNT    = 16,
  parameter int WLAT    = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            enable,
  input  logic            start,
  input  logic            done,
  input  logic            war_u,
  input  logic            war_v,
  input  logic            war_X,
  input  logic            war_Y,
  input  logic            err_u,
  input  logic            err_v,
  input  logic            err_X,
  input  logic            err_Y,
  output logic            busy,
  output logic            result_valid,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [3:0]      err_mask,
  output logic [WCNT-1:0] test_cnt,
  output logic [WCNT-1:0] war_cnt,
  output logic [WCNT-1:0] err_cnt,
  output logic [WCNT-1:0] timeout_cnt,
  output logic [WLAT-1:0] last_lat,
  output logic [WLAT-1:0] max_lat
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [WLAT-1:0] LP_TIMEOUT = WLAT'(TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_done_ev;
  logic            w_abort;
  logic [3:0]      w_err;
  logic            w_any_war;
  logic            w_fail_ev;
  logic [WLAT-1:0] r_lat;

  logic            r_result_valid;
  logic            r_pass;
  logic            r_fail;
  logic            r_timeout;
  logic [3:0]      r_err_mask;
  logic [WCNT-1:0] r_test_cnt;
  logic [WCNT-1:0] r_war_cnt;
  logic [WCNT-1:0] r_err_cnt;
  logic [WCNT-1:0] r_timeout_cnt;
  logic [WLAT-1:0] r_last_lat;
  logic [WLAT-1:0] r_max_lat;

  function automatic logic [WCNT-1:0] sat_inc(input logic [WCNT-1:0] v);
    return (v == {WCNT{1'b1}}) ? v : v + WCNT'(1);
  endfunction

  assign w_err     = {err_Y, err_X, err_v, err_u};
  assign w_any_war = war_u | war_v | war_X | war_Y;
  assign w_fail_ev = (w_done_ev & (|w_err)) | w_abort;

  // Next-state decode; done beats both restart and timeout while busy
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_done_ev = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_BUSY;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_next    = S_REPORT;
          w_done_ev = 1'b1;
        end else if (start) begin
          w_next = S_BUSY;
          w_load = 1'b1;
        end else if (r_lat >= LP_TIMEOUT) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_BUSY;
        end
      end
      S_REPORT: begin
        if (start) begin
          w_next = S_BUSY;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  // Latency counter, verdict pulses and statistics
  always_ff @(posedge clk) begin
    if (srst) begin
      r_lat          <= '0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_timeout      <= 1'b0;
      r_err_mask     <= 4'b0000;
      r_test_cnt     <= '0;
      r_war_cnt      <= '0;
      r_err_cnt      <= '0;
      r_timeout_cnt  <= '0;
      r_last_lat     <= '0;
      r_max_lat      <= '0;
    end else if (enable) begin
      r_result_valid <= w_done_ev;
      r_pass         <= w_done_ev & ~(|w_err);
      r_timeout      <= w_abort;
`ifdef BKM_SCB_STICKY_FAIL_EN
      r_fail         <= r_fail | w_fail_ev;
`else
      r_fail         <= w_fail_ev;
`endif
      if (w_load) begin
        r_lat <= WLAT'(1);
      end else if ((r_state == S_BUSY) && (r_lat != {WLAT{1'b1}})) begin
        r_lat <= r_lat + WLAT'(1);
      end
      if (w_done_ev) begin
        r_test_cnt <= sat_inc(r_test_cnt);
        r_err_mask <= w_err;
        r_last_lat <= r_lat;
        if (r_lat > r_max_lat) begin
          r_max_lat <= r_lat;
        end
        if (w_any_war) begin
          r_war_cnt <= sat_inc(r_war_cnt);
        end
        if (|w_err) begin
          r_err_cnt <= sat_inc(r_err_cnt);
        end
      end
      if (w_abort) begin
        r_timeout_cnt <= sat_inc(r_timeout_cnt);
      end
    end
  end

  assign busy         = (r_state == S_BUSY);
  assign result_valid = r_result_valid;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign err_mask     = r_err_mask;
  assign test_cnt     = r_test_cnt;
  assign war_cnt      = r_war_cnt;
  assign err_cnt      = r_err_cnt;
  assign timeout_cnt  = r_timeout_cnt;
  assign last_lat     = r_last_lat;
  assign max_lat      = r_max_lat;

endmodule

// File: tb/tb_bkm_steps_scoreboard.sv
// Directed bench: a default-parameter DUT and a small one (WCNT=2, TIMEOUT=8) share stimulus.
module tb_bkm_steps_scoreboard;

  logic clk = 1'b0;
  logic srst, enable, start, done;
  logic war_u, war_v, war_X, war_Y, err_u, err_v, err_X, err_Y;

  logic        a_busy, a_rv, a_pass, a_fail, a_to;
  logic [3:0]  a_mask;
  logic [15:0] a_tc, a_wc, a_ec, a_toc;
  logic [11:0] a_ll, a_ml;

  logic        b_busy, b_rv, b_pass, b_fail, b_to;
  logic [3:0]  b_mask;
  logic [1:0]  b_tc, b_wc, b_ec, b_toc;
  logic [11:0] b_ll, b_ml;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bkm_steps_scoreboard u_dut (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .done(done),
    .war_u(war_u), .war_v(war_v), .war_X(war_X), .war_Y(war_Y),
    .err_u(err_u), .err_v(err_v), .err_X(err_X), .err_Y(err_Y),
    .busy(a_busy), .result_valid(a_rv), .pass(a_pass), .fail(a_fail), .timeout(a_to),
    .err_mask(a_mask), .test_cnt(a_tc), .war_cnt(a_wc), .err_cnt(a_ec),
    .timeout_cnt(a_toc), .last_lat(a_ll), .max_lat(a_ml)
  );

  bkm_steps_scoreboard #(.WCNT(2), .WLAT(12), .TIMEOUT(8)) u_dut_small (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .done(done),
    .war_u(war_u), .war_v(war_v), .war_X(war_X), .war_Y(war_Y),
    .err_u(err_u), .err_v(err_v), .err_X(err_X), .err_Y(err_Y),
    .busy(b_busy), .result_valid(b_rv), .pass(b_pass), .fail(b_fail), .timeout(b_to),
    .err_mask(b_mask), .test_cnt(b_tc), .war_cnt(b_wc), .err_cnt(b_ec),
    .timeout_cnt(b_toc), .last_lat(b_ll), .max_lat(b_ml)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step(1);
    srst = 1'b0;
  endtask

  initial begin
    logic exp_busy;
    srst = 1'b1; enable = 1'b1; start = 1'b0; done = 1'b0;
    {war_u, war_v, war_X, war_Y, err_u, err_v, err_X, err_Y} = 8'h00;
    step(1);
    srst = 1'b0;

    check("rst_busy", a_busy, 0);
    check("rst_outs", {a_rv, a_pass, a_fail, a_to, a_mask}, 0);
    check("rst_cnts", {a_tc, a_wc, a_ec, a_toc}, 0);
    check("rst_lat", {a_ll, a_ml}, 0);

    // Clean test, done 5 cycles after start
    start = 1'b1; step(1); start = 1'b0;
    check("a_busy_after_start", a_busy, 1);
    step(4);
    done = 1'b1; step(1); done = 1'b0;
    check("a_rv", a_rv, 1);
    check("a_pass", a_pass, 1);
    check("a_fail_clean", a_fail, 0);
    check("a_busy_report", a_busy, 0);
    check("a_test_cnt", a_tc, 1);
    check("a_last_lat", a_ll, 5);
    check("a_max_lat", a_ml, 5);
    step(1);
    check("a_rv_drop", {a_rv, a_pass}, 0);

    // Errored test with warning, done at 3
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    done = 1'b1; err_X = 1'b1; war_u = 1'b1; step(1);
    done = 1'b0; err_X = 1'b0; war_u = 1'b0;
    check("b_mask", a_mask, 4'b0100);
    check("b_fail", a_fail, 1);
    check("b_pass", a_pass, 0);
    check("b_err_cnt", a_ec, 1);
    check("b_war_cnt", a_wc, 1);
    check("b_last_lat", a_ll, 3);
    check("b_max_keep", a_ml, 5);
    step(1);
    check("b_fail_pulse_end", a_fail, 0);

    // Clean test, done at 9
    start = 1'b1; step(1); start = 1'b0;
    step(8);
    done = 1'b1; step(1); done = 1'b0;
    check("c_last_lat", a_ll, 9);
    check("c_max_lat", a_ml, 9);
    check("c_test_cnt", a_tc, 3);
    check("c_mask_clear", a_mask, 0);
    check("c_pass", a_pass, 1);

    // Timeout on the small instance (TIMEOUT=8)
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    check("t_pre_timeout", {b_to, b_busy}, 2'b01);
    step(1);
    check("t_timeout", b_to, 1);
    check("t_timeout_cnt", b_toc, 1);
    check("t_test_cnt", b_tc, 0);
    check("t_fail", b_fail, 1);
    check("t_no_rv", b_rv, 0);
    check("t_busy", b_busy, 0);
    step(1);
    check("t_timeout_drop", b_to, 0);
`ifdef BKM_SCB_STICKY_FAIL_EN
    check("t_fail_sticky", b_fail, 1);
`else
    check("t_fail_drop", b_fail, 0);
`endif
    done = 1'b1; step(1); done = 1'b0;
    check("t_late_done", {b_rv, b_tc}, 0);

    // Five back-to-back clean tests, counters saturate at 3
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 2; c++) begin
        exp_busy = 1'b1;
        check("s_busy", b_busy, exp_busy);
        step(1);
      end
      done = 1'b1; step(1); done = 1'b0;
      check("s_report", {b_busy, b_rv}, 2'b01);
      start = (t < 4) ? 1'b1 : 1'b0;
      step(1);
      start = 1'b0;
    end
    check("s_test_cnt_sat", b_tc, 3);
    check("s_last_lat", b_ll, 3);

    // Reset in flight discards the test
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    srst = 1'b1; step(1); srst = 1'b0;
    check("r_busy", a_busy, 0);
    done = 1'b1; step(1); done = 1'b0;
    check("r_no_result", {a_rv, a_pass, a_fail}, 0);
    check("r_cnts", {a_tc, a_ec, a_wc, a_toc}, 0);
    check("r_lat", {a_ll, a_ml}, 0);

    // Frozen cycles are excluded from latency; pulses hold while disabled
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    enable = 1'b0; step(4);
    check("e_busy_hold", a_busy, 1);
    enable = 1'b1; step(1);
    done = 1'b1; step(1); done = 1'b0;
    check("e_last_lat", a_ll, 3);
    enable = 1'b0; step(2);
    check("e_rv_hold", {a_rv, a_pass}, 2'b11);
    enable = 1'b1; step(1);
    check("e_rv_release", a_rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
